mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester round-robin arbiter and sequencer for the single-port 16-bit × 1024-word `MemGen_16_10` macro wrapped by `submodule`. It accepts read and write requests from two independent clients over valid/ready handshakes and issues at most one memory access per cycle through registered macro controls. Read data returns to the originating client with a fixed latency. The block sits beside the PLL in the chip top and issues nothing until the PLL reports lock.

## Interface
Parameters:
- `ADDR_W`, 10, memory address width
- `DATA_W`, 16, memory data width
- `RD_LAT`, 1, macro read latency in cycles (legal 1..4); data is valid `RD_LAT` cycles after the edge that samples `rd_en`

Ports:
- `clock`  in  1  single clock for block and macro
- `reset`  in  1  synchronous, active-high reset
- `pll_lock`  in  1  PLL LOCK; low blocks new accepts
- `req0_valid` / `req1_valid`  in  1  request present
- `req0_write` / `req1_write`  in  1  1 = write, 0 = read
- `req0_addr` / `req1_addr`  in  ADDR_W  word address
- `req0_wdata` / `req1_wdata`  in  DATA_W  write data
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when high together with valid
- `rsp0_valid` / `rsp1_valid`  out  1  one-cycle read-data strobe; no backpressure
- `rsp0_rdata` / `rsp1_rdata`  out  DATA_W  read data
- `mem_chip_en`  out  1  macro chip enable
- `mem_wr_en`  out  1  macro write enable
- `mem_rd_en`  out  1  macro read enable
- `mem_addr`  out  ADDR_W  macro address
- `mem_wr_data`  out  DATA_W  macro write data
- `mem_rd_data`  in  DATA_W  macro read data

## Operation
- **Gate.** `open = !reset && pll_lock`. When `open` is low, both `reqN_ready` are 0.
- **Arbitration.**
  - Round-robin with a 1-bit `last` register; the reset value is 1, so requester 0 wins the first contention.
  - With one request valid, it is granted.
  - With both valid, the requester other than `last` is granted.
  - `last` updates only on an accepted handshake.
- **Ready.** `reqN_ready = open && grantN`. Ready is combinational from valid and `last`; at most one ready is high per cycle.
- **Issue stage.** This stage is registered.
  - On accept at edge E0, the cycle after E0 drives `mem_chip_en=1` with the accepted address and data.
  - For a write: `mem_wr_en=1`, `mem_rd_en=0`.
  - For a read: `mem_rd_en=1`, `mem_wr_en=0`.
  - With no accept, all `mem_*` controls return to 0; address and data hold their last values.
- **Response tracking.**
  - A shift register `RD_LAT+1` deep carries `{valid, id}` for each issued read.
  - At edge E0+1+RD_LAT, `mem_rd_data` is captured into `rspN_rdata` of the tagged requester, and `rspN_valid` is pulsed for one cycle.
  - The other requester's `rdata` holds its value.
- **Ordering.** There is a single issue stream, so accesses complete in accept order. A read accepted after a write to the same address returns the new data.
- **Lock loss.** If `pll_lock` falls with reads in flight, those reads still complete and respond. Only new accepts are blocked.
- **Reset.**
  - All `mem_*` outputs are 0, `rspN_valid`=0, `rspN_rdata`=0, the tracker is cleared and `last`=1.
  - Reads in flight when `reset` asserts are dropped; no response is produced.

## Timing
- Throughput: one access per cycle, sustained back-to-back. Reads and writes interleave freely with no bubbles.
- Accept-to-macro latency: 1 cycle; controls are valid in the cycle after the accept edge.
- Accept-to-response latency: `RD_LAT+1` edges after the accept edge. With `RD_LAT=1`, `rsp_valid` is high in the cycle starting at E0+2.
- Writes produce no response.
- Reset values: every output is 0, including `reqN_ready`, because `reset` gates `open` combinationally.
- In the first cycle after `reset` deasserts with `pll_lock` high, a valid request is accepted immediately.
- Simultaneous events:
  - An accept and a response for the other requester may occur in the same cycle.
  - Two responses never coincide, because issue is serial.

## Test plan
- **Basic write/read.** With `RD_LAT=1` and lock high: req0 writes 0xA5A5 to addr 0x3FF, then reads 0x3FF back-to-back. Required: `mem_wr_en` is high one cycle after the write accept, and `rsp0_valid` pulses 2 cycles after the read accept with `rsp0_rdata`=0xA5A5; `rsp1_valid` stays 0.
- **Contention.** Both requesters hold valid reads (addr 0x001 and 0x002) for 4 cycles. Required: the grant sequence is 0,1,0,1 and `mem_addr` is 0x001,0x002,0x001,0x002 on consecutive cycles, with responses routed to rsp0/rsp1 in that order.
- **Lock gating.** Hold `pll_lock`=0 with req1 valid for 5 cycles, then raise it. Required: `req1_ready`=0 and `mem_chip_en`=0 throughout, and the accept occurs in the first cycle with lock high.
- **Lock drop in flight.** Lower lock the cycle after a read accept. Required: the response still arrives at the nominal latency, and no further accepts occur.
- **Reset mid-read.** Assert `reset` one cycle after a read accept. Required: no `rsp_valid` ever appears for that read, all outputs are 0 during reset, and after reset the first contention grants requester 0.
- **Latency parameter.** With `RD_LAT=3`, issue a read. Required: `rsp_valid` arrives exactly 4 edges after the accept, with correct data.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Client and macro-side signal bundle for mem_port_arbiter.
// The slave modport is the arbiter's view; master is the clients plus macro.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    // Requester 0
    logic              req0_valid;
    logic              req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;

    // Requester 1
    logic              req1_valid;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    // Memory macro
    logic              mem_chip_en;
    logic              mem_wr_en;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        input  mem_rd_data,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output mem_chip_en, mem_wr_en, mem_rd_en, mem_addr, mem_wr_data
    );

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        output mem_rd_data,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  mem_chip_en, mem_wr_en, mem_rd_en, mem_addr, mem_wr_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-client round-robin arbiter and sequencer for a single-port memory macro.
// One access issues per cycle through registered macro controls; read data
// returns to the originating client RD_LAT+1 edges after the accept edge.
// New accepts are blocked while reset is high or the PLL is not locked.
module mem_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pll_lock,
    mem_port_arbiter_if.slave bus
);

    // Arbitration and accept-side signals
    logic              open_s;
    logic              grant0_s;
    logic              grant1_s;
    logic              ready0_s;
    logic              ready1_s;
    logic              accept_s;
    logic              acc_id_s;
    logic              acc_write_s;
    logic [ADDR_W-1:0] acc_addr_s;
    logic [DATA_W-1:0] acc_wdata_s;

    // Round-robin pointer: requester that won the most recent accept
    logic              last_r;

    // Issue stage driving the macro
    logic              chip_en_r;
    logic              wr_en_r;
    logic              rd_en_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;

    // Read tracker: stage k holds a read accepted k edges ago; the oldest
    // stage lines up with the macro presenting that read's data.
    logic [RD_LAT:0]   trk_vld_r;
    logic [RD_LAT:0]   trk_id_r;

    // Response outputs
    logic              rsp0_valid_r;
    logic              rsp1_valid_r;
    logic [DATA_W-1:0] rsp0_rdata_r;
    logic [DATA_W-1:0] rsp1_rdata_r;

    // Grant selection: a lone request wins, contention goes to the non-last one
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        case ({bus.req1_valid, bus.req0_valid})
            2'b01: begin
                grant0_s = 1'b1;
            end
            2'b10: begin
                grant1_s = 1'b1;
            end
            2'b11: begin
                grant0_s = last_r;
                grant1_s = ~last_r;
            end
            default: begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        endcase
    end

    // Ready gating and selection of the accepted request's fields
    always_comb begin
        open_s      = ~reset & pll_lock;
        ready0_s    = open_s & grant0_s;
        ready1_s    = open_s & grant1_s;
        accept_s    = ready0_s | ready1_s;
        acc_id_s    = ready1_s;
        acc_write_s = 1'b0;
        acc_addr_s  = {ADDR_W{1'b0}};
        acc_wdata_s = {DATA_W{1'b0}};
        if (ready1_s) begin
            acc_write_s = bus.req1_write;
            acc_addr_s  = bus.req1_addr;
            acc_wdata_s = bus.req1_wdata;
        end else begin
            acc_write_s = bus.req0_write;
            acc_addr_s  = bus.req0_addr;
            acc_wdata_s = bus.req0_wdata;
        end
    end

    // Round-robin pointer moves only on an accepted handshake
    always_ff @(posedge clock) begin
        if (reset) begin
            last_r <= 1'b1;
        end else if (accept_s) begin
            last_r <= acc_id_s;
        end
    end

    // Issue stage: strobes follow the accept, address/data hold when idle
    always_ff @(posedge clock) begin
        if (reset) begin
            chip_en_r <= 1'b0;
            wr_en_r   <= 1'b0;
            rd_en_r   <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
        end else begin
            chip_en_r <= accept_s;
            wr_en_r   <= accept_s & acc_write_s;
            rd_en_r   <= accept_s & ~acc_write_s;
            if (accept_s) begin
                addr_r  <= acc_addr_s;
                wdata_r <= acc_wdata_s;
            end
        end
    end

    // Read tracker shift; reset drops every read still in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            trk_vld_r <= {(RD_LAT + 1){1'b0}};
            trk_id_r  <= {(RD_LAT + 1){1'b0}};
        end else begin
            trk_vld_r <= {trk_vld_r[RD_LAT-1:0], accept_s & ~acc_write_s};
            trk_id_r  <= {trk_id_r[RD_LAT-1:0], acc_id_s};
        end
    end

    // Capture macro read data into the tagged requester's response register
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            rsp0_rdata_r <= {DATA_W{1'b0}};
            rsp1_rdata_r <= {DATA_W{1'b0}};
        end else begin
            rsp0_valid_r <= trk_vld_r[RD_LAT] & ~trk_id_r[RD_LAT];
            rsp1_valid_r <= trk_vld_r[RD_LAT] & trk_id_r[RD_LAT];
            if (trk_vld_r[RD_LAT] & ~trk_id_r[RD_LAT]) begin
                rsp0_rdata_r <= bus.mem_rd_data;
            end
            if (trk_vld_r[RD_LAT] & trk_id_r[RD_LAT]) begin
                rsp1_rdata_r <= bus.mem_rd_data;
            end
        end
    end

    assign bus.req0_ready  = ready0_s;
    assign bus.req1_ready  = ready1_s;
    assign bus.rsp0_valid  = rsp0_valid_r;
    assign bus.rsp1_valid  = rsp1_valid_r;
    assign bus.rsp0_rdata  = rsp0_rdata_r;
    assign bus.rsp1_rdata  = rsp1_rdata_r;
    assign bus.mem_chip_en = chip_en_r;
    assign bus.mem_wr_en   = wr_en_r;
    assign bus.mem_rd_en   = rd_en_r;
    assign bus.mem_addr    = addr_r;
    assign bus.mem_wr_data = wdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance A with RD_LAT=1, instance B with
// RD_LAT=3, each beside a small behavioural macro. Expected read responses
// are queued when stimulus is issued and checked by per-instance monitors.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;

    typedef struct {
        logic        id;
        logic [15:0] data;
        int          due;
    } exp_t;

    logic clock = 1'b0;
    logic rst_a;
    logic lock_a;
    logic rst_b;
    logic lock_b;
    int   cyc  = 0;
    int   nchk = 0;
    int   nerr = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clock = ~clock;

    // Cycle counter used for response latency checks
    always @(posedge clock) cyc <= cyc + 1;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifa ();
    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifb ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) dut_a (
        .clock(clock), .reset(rst_a), .pll_lock(lock_a), .bus(ifa)
    );
    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(3)) dut_b (
        .clock(clock), .reset(rst_b), .pll_lock(lock_b), .bus(ifb)
    );

    // Behavioural macro A: read data valid one cycle after the sampling edge
    logic [15:0] mem_a [0:1023];
    logic [15:0] rd_a;
    always @(posedge clock) begin
        if (rst_a) begin
            mem_a[10'h001] <= 16'h1111;
            mem_a[10'h002] <= 16'h2222;
        end else begin
            if (ifa.mem_chip_en && ifa.mem_wr_en) mem_a[ifa.mem_addr] <= ifa.mem_wr_data;
            if (ifa.mem_chip_en && ifa.mem_rd_en) rd_a <= mem_a[ifa.mem_addr];
        end
    end
    assign ifa.mem_rd_data = rd_a;

    // Behavioural macro B: three-stage read pipeline
    logic [15:0] mem_b [0:1023];
    logic [15:0] rd_b0, rd_b1, rd_b2;
    always @(posedge clock) begin
        if (rst_b) begin
            mem_b[10'h155] <= 16'hBEEF;
        end else begin
            if (ifb.mem_chip_en && ifb.mem_wr_en) mem_b[ifb.mem_addr] <= ifb.mem_wr_data;
            if (ifb.mem_chip_en && ifb.mem_rd_en) rd_b0 <= mem_b[ifb.mem_addr];
        end
        rd_b1 <= rd_b0;
        rd_b2 <= rd_b1;
    end
    assign ifb.mem_rd_data = rd_b2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic req_a(input int id, input logic v, input logic w,
                         input logic [9:0] a, input logic [15:0] d);
        if (id == 0) begin
            ifa.req0_valid = v; ifa.req0_write = w; ifa.req0_addr = a; ifa.req0_wdata = d;
        end else begin
            ifa.req1_valid = v; ifa.req1_write = w; ifa.req1_addr = a; ifa.req1_wdata = d;
        end
    endtask

    task automatic req_b(input int id, input logic v, input logic w,
                         input logic [9:0] a, input logic [15:0] d);
        if (id == 0) begin
            ifb.req0_valid = v; ifb.req0_write = w; ifb.req0_addr = a; ifb.req0_wdata = d;
        end else begin
            ifb.req1_valid = v; ifb.req1_write = w; ifb.req1_addr = a; ifb.req1_wdata = d;
        end
    endtask

    // Call in the cycle before the accept edge
    task automatic exp_a(input logic id, input logic [15:0] d);
        exp_t e;
        e.id = id; e.data = d; e.due = cyc + 2 + 1;
        qa.push_back(e);
    endtask

    task automatic exp_b(input logic id, input logic [15:0] d);
        exp_t e;
        e.id = id; e.data = d; e.due = cyc + 2 + 3;
        qb.push_back(e);
    endtask

    // Monitor A: every response must match the oldest queued expectation
    always @(negedge clock) begin
        exp_t e;
        if (ifa.rsp0_valid && ifa.rsp1_valid) begin
            nchk++; nerr++;
            $display("FAIL a_rsp_overlap: both rsp valids high at cycle %0d", cyc);
        end else if (ifa.rsp0_valid || ifa.rsp1_valid) begin
            if (qa.size() == 0) begin
                nchk++; nerr++;
                $display("FAIL a_rsp_unexpected: rsp1_valid=%0b at cycle %0d, nothing outstanding",
                         ifa.rsp1_valid, cyc);
            end else begin
                e = qa.pop_front();
                chk("a_rsp_id", {31'd0, ifa.rsp1_valid}, {31'd0, e.id});
                chk("a_rsp_data", ifa.rsp1_valid ? ifa.rsp1_rdata : ifa.rsp0_rdata, e.data);
                chk("a_rsp_cycle", cyc, e.due);
            end
        end
    end

    // Monitor B: same scoreboard against the RD_LAT=3 instance
    always @(negedge clock) begin
        exp_t e;
        if (ifb.rsp0_valid && ifb.rsp1_valid) begin
            nchk++; nerr++;
            $display("FAIL b_rsp_overlap: both rsp valids high at cycle %0d", cyc);
        end else if (ifb.rsp0_valid || ifb.rsp1_valid) begin
            if (qb.size() == 0) begin
                nchk++; nerr++;
                $display("FAIL b_rsp_unexpected: rsp1_valid=%0b at cycle %0d, nothing outstanding",
                         ifb.rsp1_valid, cyc);
            end else begin
                e = qb.pop_front();
                chk("b_rsp_id", {31'd0, ifb.rsp1_valid}, {31'd0, e.id});
                chk("b_rsp_data", ifb.rsp1_valid ? ifb.rsp1_rdata : ifb.rsp0_rdata, e.data);
                chk("b_rsp_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        rst_a = 1'b1; lock_a = 1'b1; rst_b = 1'b1; lock_b = 1'b1;
        req_a(0, 1'b1, 1'b0, 10'h001, 16'h0000);
        req_a(1, 1'b1, 1'b0, 10'h002, 16'h0000);
        req_b(0, 1'b0, 1'b0, 10'h000, 16'h0000);
        req_b(1, 1'b0, 1'b0, 10'h000, 16'h0000);
        tick(); tick();

        // Reset state with both requests pending
        @(negedge clock);
        chk("rst_ready0", {31'd0, ifa.req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, ifa.req1_ready}, 32'd0);
        chk("rst_chip_en", {31'd0, ifa.mem_chip_en}, 32'd0);
        chk("rst_wr_en", {31'd0, ifa.mem_wr_en}, 32'd0);
        chk("rst_rd_en", {31'd0, ifa.mem_rd_en}, 32'd0);
        chk("rst_addr", {22'd0, ifa.mem_addr}, 32'd0);
        chk("rst_wdata", {16'd0, ifa.mem_wr_data}, 32'd0);
        chk("rst_rsp0_rdata", {16'd0, ifa.rsp0_rdata}, 32'd0);
        chk("rst_rsp1_rdata", {16'd0, ifa.rsp1_rdata}, 32'd0);
        tick();

        // Basic write then read of 0x3FF on requester 0
        rst_a = 1'b0;
        req_a(1, 1'b0, 1'b0, 10'h000, 16'h0000);
        req_a(0, 1'b1, 1'b1, 10'h3FF, 16'hA5A5);
        @(negedge clock);
        chk("first_accept_ready0", {31'd0, ifa.req0_ready}, 32'd1);
        tick();
        req_a(0, 1'b1, 1'b0, 10'h3FF, 16'h0000);
        exp_a(1'b0, 16'hA5A5);
        @(negedge clock);
        chk("wr_chip_en", {31'd0, ifa.mem_chip_en}, 32'd1);
        chk("wr_wr_en", {31'd0, ifa.mem_wr_en}, 32'd1);
        chk("wr_rd_en", {31'd0, ifa.mem_rd_en}, 32'd0);
        chk("wr_addr", {22'd0, ifa.mem_addr}, 32'h3FF);
        chk("wr_wdata", {16'd0, ifa.mem_wr_data}, 32'hA5A5);
        chk("b2b_ready0", {31'd0, ifa.req0_ready}, 32'd1);
        tick();
        req_a(0, 1'b0, 1'b0, 10'h000, 16'h0000);
        @(negedge clock);
        chk("rd_rd_en", {31'd0, ifa.mem_rd_en}, 32'd1);
        chk("rd_wr_en", {31'd0, ifa.mem_wr_en}, 32'd0);
        tick();
        @(negedge clock);
        chk("idle_chip_en", {31'd0, ifa.mem_chip_en}, 32'd0);
        chk("idle_addr_hold", {22'd0, ifa.mem_addr}, 32'h3FF);
        tick(); tick();

        // Reset one cycle after a read accept: that read must never respond
        req_a(0, 1'b1, 1'b0, 10'h3FF, 16'h0000);
        tick();
        rst_a = 1'b1;
        req_a(0, 1'b1, 1'b0, 10'h001, 16'h0000);
        req_a(1, 1'b1, 1'b0, 10'h002, 16'h0000);
        @(negedge clock);
        chk("rstmid_ready0", {31'd0, ifa.req0_ready}, 32'd0);
        chk("rstmid_ready1", {31'd0, ifa.req1_ready}, 32'd0);
        tick();
        @(negedge clock);
        chk("rstmid_chip_en", {31'd0, ifa.mem_chip_en}, 32'd0);
        chk("rstmid_rd_en", {31'd0, ifa.mem_rd_en}, 32'd0);
        chk("rstmid_addr", {22'd0, ifa.mem_addr}, 32'd0);
        chk("rstmid_rsp0_valid", {31'd0, ifa.rsp0_valid}, 32'd0);
        chk("rstmid_rsp0_rdata", {16'd0, ifa.rsp0_rdata}, 32'd0);
        tick();

        // Contention straight out of reset: grants 0,1,0,1
        rst_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_a(i[0], i[0] ? 16'h2222 : 16'h1111);
            @(negedge clock);
            chk("cont_ready0", {31'd0, ifa.req0_ready}, {31'd0, ~i[0]});
            chk("cont_ready1", {31'd0, ifa.req1_ready}, {31'd0, i[0]});
            if (i > 0) chk("cont_mem_addr", {22'd0, ifa.mem_addr}, i[0] ? 32'h001 : 32'h002);
            tick();
        end
        req_a(0, 1'b0, 1'b0, 10'h000, 16'h0000);
        req_a(1, 1'b0, 1'b0, 10'h000, 16'h0000);
        @(negedge clock);
        chk("cont_mem_addr_last", {22'd0, ifa.mem_addr}, 32'h002);
        tick();

        // Lock gating: req1 waits five cycles, accepted on the first locked cycle
        lock_a = 1'b0;
        req_a(1, 1'b1, 1'b0, 10'h002, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("lock_ready1", {31'd0, ifa.req1_ready}, 32'd0);
            chk("lock_chip_en", {31'd0, ifa.mem_chip_en}, 32'd0);
            tick();
        end
        lock_a = 1'b1;
        exp_a(1'b1, 16'h2222);
        @(negedge clock);
        chk("lock_up_ready1", {31'd0, ifa.req1_ready}, 32'd1);
        tick();
        req_a(1, 1'b0, 1'b0, 10'h000, 16'h0000);
        @(negedge clock);
        chk("lock_up_rd_en", {31'd0, ifa.mem_rd_en}, 32'd1);
        chk("lock_up_addr", {22'd0, ifa.mem_addr}, 32'h002);
        tick();

        // Lock drop the cycle after a read accept: read completes, nothing new accepted
        req_a(0, 1'b1, 1'b0, 10'h001, 16'h0000);
        exp_a(1'b0, 16'h1111);
        tick();
        lock_a = 1'b0;
        req_a(1, 1'b1, 1'b0, 10'h002, 16'h0000);
        for (int j = 0; j < 4; j++) begin
            @(negedge clock);
            chk("drop_ready0", {31'd0, ifa.req0_ready}, 32'd0);
            chk("drop_ready1", {31'd0, ifa.req1_ready}, 32'd0);
            chk("drop_chip_en", {31'd0, ifa.mem_chip_en}, (j == 0) ? 32'd1 : 32'd0);
            tick();
        end
        req_a(0, 1'b0, 1'b0, 10'h000, 16'h0000);
        req_a(1, 1'b0, 1'b0, 10'h000, 16'h0000);
        lock_a = 1'b1;
        tick(); tick();

        // Instance B, RD_LAT=3: write/read ordering and latency
        rst_b = 1'b0;
        req_b(0, 1'b1, 1'b1, 10'h0AA, 16'h1234);
        @(negedge clock);
        chk("b_ready0", {31'd0, ifb.req0_ready}, 32'd1);
        tick();
        req_b(0, 1'b1, 1'b0, 10'h0AA, 16'h0000);
        exp_b(1'b0, 16'h1234);
        tick();
        req_b(0, 1'b0, 1'b0, 10'h000, 16'h0000);
        req_b(1, 1'b1, 1'b0, 10'h155, 16'h0000);
        exp_b(1'b1, 16'hBEEF);
        tick();
        req_b(1, 1'b0, 1'b0, 10'h000, 16'h0000);
        for (int i = 0; i < 7; i++) tick();

        // Instance B: reset one cycle after a read accept drops the deep in-flight read
        req_b(1, 1'b1, 1'b0, 10'h155, 16'h0000);
        tick();
        req_b(1, 1'b0, 1'b0, 10'h000, 16'h0000);
        rst_b = 1'b1;
        tick(); tick();
        rst_b = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        chk("a_drain", qa.size(), 32'd0);
        chk("b_drain", qb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
